// File: rtl/countdown_pkg.sv
// Shared types and helpers for the countdown overlay: FSM states, 4-bit RGB
// triple, palette index width and the 50 % blend used by the optional fade.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] red;
        logic [3:0] green;
        logic [3:0] blue;
    } rgb4_t;

    localparam int PAL_BITS = 2;

    function automatic logic [3:0] blend4(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[4:1];
    endfunction

    function automatic rgb4_t blend_rgb(input rgb4_t a, input rgb4_t b);
        rgb4_t mix;
        mix.red   = blend4(a.red,   b.red);
        mix.green = blend4(a.green, b.green);
        mix.blue  = blend4(a.blue,  b.blue);
        return mix;
    endfunction

endpackage

// File: rtl/countdown_rom.sv
// Sprite ROM holding all digit frames back-to-back (frame, row, column order),
// registered read on the rising pixel clock edge.
module countdown_rom
    import countdown_pkg::*;
#(
    parameter int DEPTH  = 16384,
    parameter int WIDTH  = PAL_BITS,
    parameter int X_BITS = 6,
    parameter int Y_BITS = 6,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic             vga_clk,
    input  logic [AW-1:0]    addr,
    output logic [WIDTH-1:0] q
);

    // Built-in glyph image: each texel index mixes its column, row and frame
    // fields so every frame shows a distinct checker of transparent and opaque
    // texels. Replace this function body to load real artwork.
    function automatic logic [WIDTH-1:0] image_word(input logic [AW-1:0] a);
        logic [AW-1:0] t;
        t = a ^ (a >> X_BITS) ^ (a >> (X_BITS + Y_BITS));
        return t[WIDTH-1:0];
    endfunction

    // Synchronous read port.
    always_ff @(posedge vga_clk) begin
        q <= image_word(addr);
    end

endmodule

// File: rtl/countdown_sequencer.sv
// "3, 2, 1, FIGHT" countdown overlay composited onto the VGA pixel stream.
// Optional fade-out blend of each digit is enabled with COUNTDOWN_FADE_EN.
module countdown_sequencer
    import countdown_pkg::*;
#(
    parameter int SPRITE_W         = 64,
    parameter int SPRITE_H         = 64,
    parameter int NUM_DIGITS       = 4,
    parameter int FRAMES_PER_DIGIT = 60,
    parameter int SCALE_SHIFT      = 2,
    parameter int X0               = 192,
    parameter int Y0               = 112,
    parameter int V_ACTIVE         = 480,
    parameter int FADE_FRAMES      = 15
) (
    input  logic                          vga_clk,
    input  logic                          Reset,
    input  logic                          start,
    input  logic [9:0]                    DrawX,
    input  logic [9:0]                    DrawY,
    input  logic                          blank,
    input  logic [3:0]                    bg_red,
    input  logic [3:0]                    bg_green,
    input  logic [3:0]                    bg_blue,
    output logic [3:0]                    red,
    output logic [3:0]                    green,
    output logic [3:0]                    blue,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

    localparam int DIG_W     = $clog2(NUM_DIGITS);
    localparam int ROM_DEPTH = NUM_DIGITS * SPRITE_W * SPRITE_H;
    localparam int ADDR_W    = $clog2(ROM_DEPTH);
    localparam int TX_W      = $clog2(SPRITE_W);
    localparam int TY_W      = $clog2(SPRITE_H);
    localparam int CNT_W     = $clog2(FRAMES_PER_DIGIT + 1);

    localparam logic [10:0]      X_LO     = 11'(X0);
    localparam logic [10:0]      X_HI     = 11'(X0 + (SPRITE_W << SCALE_SHIFT));
    localparam logic [10:0]      Y_LO     = 11'(Y0);
    localparam logic [10:0]      Y_HI     = 11'(Y0 + (SPRITE_H << SCALE_SHIFT));
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_DIGIT - 1);
    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_FADE =
        (FADE_FRAMES >= FRAMES_PER_DIGIT) ? CNT_W'(0) : CNT_W'(FRAMES_PER_DIGIT - FADE_FRAMES);

`ifdef COUNTDOWN_FADE_EN
    localparam bit FADE_ON = 1'b1;
`else
    localparam bit FADE_ON = 1'b0;
`endif

    state_t             state_r;
    logic [DIG_W-1:0]   digit_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               busy_r;
    logic               done_r;
    logic               tick_r;

    logic [10:0]        x_s;
    logic [10:0]        y_s;
    logic [10:0]        dx_s;
    logic [10:0]        dy_s;
    logic [TX_W-1:0]    tx_s;
    logic [TY_W-1:0]    ty_s;
    logic [ADDR_W-1:0]  addr_s;
    logic               inside_s;
    logic               fade_s;

    logic               inside_r;
    logic               blank_r;
    logic               fade_r;
    rgb4_t              bg_r;

    logic [PAL_BITS-1:0] pal_idx_s;
    rgb4_t              pal_s;
    rgb4_t              mix_s;
    rgb4_t              out_r;

    // Frame tick: one pulse per frame when the scan passes the first blank line.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            tick_r <= 1'b0;
        end else begin
            tick_r <= (DrawX == 10'd0) && (DrawY == 10'(V_ACTIVE));
        end
    end

    // Countdown FSM; busy/done/digit are registered alongside the state.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            state_r <= IDLE;
            digit_r <= '0;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r <= RUN;
                        digit_r <= '0;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                RUN: begin
                    if (tick_r) begin
                        if (cnt_r == CNT_LAST) begin
                            cnt_r <= '0;
                            if (digit_r == DIG_LAST) begin
                                // Digit index is held on the last frame until the next start.
                                state_r <= FINISH;
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                            end else begin
                                digit_r <= digit_r + DIG_W'(1);
                            end
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                end
                FINISH: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1 hit test and address; 11-bit compares keep off-screen parts from wrapping.
    always_comb begin
        x_s      = {1'b0, DrawX};
        y_s      = {1'b0, DrawY};
        dx_s     = x_s - X_LO;
        dy_s     = y_s - Y_LO;
        tx_s     = TX_W'(dx_s >> SCALE_SHIFT);
        ty_s     = TY_W'(dy_s >> SCALE_SHIFT);
        inside_s = (state_r == RUN) && (x_s >= X_LO) && (x_s < X_HI)
                   && (y_s >= Y_LO) && (y_s < Y_HI);
        addr_s   = ADDR_W'(digit_r) * ADDR_W'(SPRITE_W * SPRITE_H)
                   + ADDR_W'(ty_s) * ADDR_W'(SPRITE_W) + ADDR_W'(tx_s);
        fade_s   = (cnt_r >= CNT_FADE);
    end

    countdown_rom #(
        .DEPTH  (ROM_DEPTH),
        .WIDTH  (PAL_BITS),
        .X_BITS (TX_W),
        .Y_BITS (TY_W)
    ) u_rom (
        .vga_clk (vga_clk),
        .addr    (addr_s),
        .q       (pal_idx_s)
    );

    // Stage 1 side-band registers, aligned with the ROM read register.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            inside_r <= 1'b0;
            blank_r  <= 1'b0;
            fade_r   <= 1'b0;
            bg_r     <= '0;
        end else begin
            inside_r <= inside_s;
            blank_r  <= blank;
            fade_r   <= fade_s;
            bg_r     <= '{red: bg_red, green: bg_green, blue: bg_blue};
        end
    end

    // Palette: index 0 is transparent and never displayed.
    always_comb begin
        pal_s = '0;
        case (pal_idx_s)
            PAL_BITS'(1): pal_s = '{red: 4'hF, green: 4'hF, blue: 4'hF};
            PAL_BITS'(2): pal_s = '{red: 4'hF, green: 4'h8, blue: 4'h0};
            PAL_BITS'(3): pal_s = '{red: 4'hF, green: 4'h0, blue: 4'h0};
            default:      pal_s = '0;
        endcase
    end

    // Stage 2 compositing.
    always_comb begin
        mix_s = bg_r;
        if (!blank_r) begin
            mix_s = '0;
        end else if (inside_r && (pal_idx_s != '0)) begin
            if (FADE_ON && fade_r) begin
                mix_s = blend_rgb(pal_s, bg_r);
            end else begin
                mix_s = pal_s;
            end
        end else begin
            mix_s = bg_r;
        end
    end

    // Output colour register.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            out_r <= '0;
        end else begin
            out_r <= mix_s;
        end
    end

    assign red       = out_r.red;
    assign green     = out_r.green;
    assign blue      = out_r.blue;
    assign busy      = busy_r;
    assign done      = done_r;
    assign digit_idx = digit_r;

endmodule
